// File: rtl/ifu_pfb.sv
// Sequential instruction fetch unit with a PC-tagged prefetch FIFO.
// Several fetches may be in flight; a redirect flushes the FIFO and drops stale responses.
module ifu_pfb #(
  parameter int unsigned       XLEN      = 32,
  parameter int unsigned       DEPTH     = 4,
  parameter int unsigned       MAX_OUTST = 2,
  parameter logic [XLEN-1:0]   RESET_PC  = 32'h80000000,
  parameter int unsigned       PC_INC    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            hs_rd4ls_val,
  input  logic            hs_ls4rd_rdy,
  output logic [XLEN-1:0] o_pc_nx,
  input  logic            i_rsp_val,
  input  logic [XLEN-1:0] i_in_r,
  output logic            val,
  input  logic            rdy,
  output logic [XLEN-1:0] o_in,
  output logic [XLEN-1:0] o_pc_r,
  input  logic            i_setpc,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_pcadd
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTST + 1);
  localparam int unsigned SW = $clog2(DEPTH + MAX_OUTST + 1);
  localparam logic [XLEN-1:0] INC = XLEN'(PC_INC);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [OW-1:0]   outst_q, outst_d;
  logic [OW-1:0]   drop_q, drop_d;

  logic [XLEN-1:0] ins_q [DEPTH];
  logic [XLEN-1:0] tag_q [DEPTH];

  logic [XLEN-1:0] target;
  logic [SW-1:0]   occupancy;
  logic            req_fire;
  logic            rsp_ok;
  logic            push;
  logic            pop;

  // Occupancy counts entries held plus entries still owed by useful in-flight fetches.
  assign occupancy    = SW'(count_q) + SW'(outst_q) - SW'(drop_q);
  assign hs_rd4ls_val = rst_n && !i_setpc && (outst_q < OW'(MAX_OUTST)) && (occupancy < SW'(DEPTH));
  assign o_pc_nx      = fetch_pc_q;
  assign val          = (count_q != '0);
  assign o_in         = ins_q[rd_ptr_q];
  assign o_pc_r       = tag_q[rd_ptr_q];

  assign target   = i_pc + i_pcadd;
  assign req_fire = hs_rd4ls_val && hs_ls4rd_rdy;
  assign rsp_ok   = i_rsp_val && (outst_q != '0);
  assign pop      = val && rdy;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    drop_d     = drop_q;
    push       = 1'b0;
    outst_d    = outst_q;

    if (req_fire && !rsp_ok) begin
      outst_d = outst_q + OW'(1);
    end else if (!req_fire && rsp_ok) begin
      outst_d = outst_q - OW'(1);
    end

    if (i_setpc) begin
      fetch_pc_d = target;
      rsp_pc_d   = target;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      drop_d     = rsp_ok ? (outst_q - OW'(1)) : outst_q;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + INC;
      end
      if (rsp_ok) begin
        if (drop_q != '0) begin
          drop_d = drop_q - OW'(1);
        end else begin
          push     = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          rsp_pc_d = rsp_pc_q + INC;
        end
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  // Storage is cleared by reset so the head outputs show known values while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ins_q[i] <= '0;
        tag_q[i] <= RESET_PC;
      end
    end else if (push) begin
      ins_q[wr_ptr_q] <= i_in_r;
      tag_q[wr_ptr_q] <= rsp_pc_q;
    end
  end

endmodule

// File: tb/tb_ifu_pfb.sv
// Directed testbench for ifu_pfb: streaming, backpressure, redirects, PC wrap and async reset.
module tb_ifu_pfb;

  localparam logic [31:0] RPC = 32'h80000000;

  logic        clk;
  logic        rst_n;
  logic        hs_rd4ls_val;
  logic        hs_ls4rd_rdy;
  logic [31:0] o_pc_nx;
  logic        i_rsp_val;
  logic [31:0] i_in_r;
  logic        val;
  logic        rdy;
  logic [31:0] o_in;
  logic [31:0] o_pc_r;
  logic        i_setpc;
  logic [31:0] i_pc;
  logic [31:0] i_pcadd;

  int n_assert = 0;
  int n_fail   = 0;
  logic hold;
  logic inject_late;
  logic [31:0] mem_q[$];
  logic [31:0] fire_q[$];

  ifu_pfb dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hs_rd4ls_val (hs_rd4ls_val),
    .hs_ls4rd_rdy (hs_ls4rd_rdy),
    .o_pc_nx      (o_pc_nx),
    .i_rsp_val    (i_rsp_val),
    .i_in_r       (i_in_r),
    .val          (val),
    .rdy          (rdy),
    .o_in         (o_in),
    .o_pc_r       (o_pc_r),
    .i_setpc      (i_setpc),
    .i_pc         (i_pc),
    .i_pcadd      (i_pcadd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Protocol and invariant monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      n_assert++;
      if (i_rsp_val && dut.outst_q == 0 && !inject_late) begin
        n_fail++;
        $display("FAIL protocol: response with outst=%0d required outst>0", dut.outst_q);
      end
      n_assert++;
      if (!(dut.drop_q <= dut.outst_q && int'(dut.outst_q) <= 2)) begin
        n_fail++;
        $display("FAIL inv_outst: drop=%0d outst=%0d required drop<=outst<=2", dut.drop_q, dut.outst_q);
      end
      n_assert++;
      if (int'(dut.count_q) + int'(dut.outst_q) - int'(dut.drop_q) > 4) begin
        n_fail++;
        $display("FAIL inv_space: count=%0d outst=%0d drop=%0d required occupancy<=4",
                 dut.count_q, dut.outst_q, dut.drop_q);
      end
    end
  end

  // One clock: capture an accepted request, then drive the memory response one cycle later.
  task automatic tick();
    #1;
    if (hs_rd4ls_val && hs_ls4rd_rdy) begin
      fire_q.push_back(o_pc_nx);
      mem_q.push_back(o_pc_nx);
    end
    @(posedge clk);
    #1;
    inject_late = 1'b0;
    if (!hold && mem_q.size() > 0) begin
      i_rsp_val = 1'b1;
      i_in_r    = mem_q.pop_front();
    end else begin
      i_rsp_val = 1'b0;
      i_in_r    = '0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; i_setpc = 1'b0; i_pc = '0; i_pcadd = '0;
    i_rsp_val = 1'b0; i_in_r = '0; rdy = 1'b0; hs_ls4rd_rdy = 1'b1;
    hold = 1'b0; inject_late = 1'b0;
    mem_q.delete(); fire_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_setpc = 1'b0; i_pc = '0; i_pcadd = '0;
    i_rsp_val = 1'b0; i_in_r = '0; rdy = 1'b0; hs_ls4rd_rdy = 1'b1;
    hold = 1'b0; inject_late = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_assert++; if (val !== 1'b0) begin n_fail++; $display("FAIL reset_val: got %b required 0", val); end
    n_assert++; if (hs_rd4ls_val !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b required 0", hs_rd4ls_val); end
    n_assert++; if (o_in !== 32'h0) begin n_fail++; $display("FAIL reset_o_in: got %h required 00000000", o_in); end
    n_assert++; if (o_pc_r !== RPC) begin n_fail++; $display("FAIL reset_o_pc_r: got %h required %h", o_pc_r, RPC); end
    n_assert++; if (o_pc_nx !== RPC) begin n_fail++; $display("FAIL reset_o_pc_nx: got %h required %h", o_pc_nx, RPC); end
    rst_n = 1'b1;
    $display("reset: outputs at reset values checked");
  endtask

  task automatic test_stream();
    do_reset(); rdy = 1'b1;
    #1;
    n_assert++; if (hs_rd4ls_val !== 1'b1 || o_pc_nx !== RPC) begin
      n_fail++; $display("FAIL stream_first_req: got val=%b addr=%h required 1 %h", hs_rd4ls_val, o_pc_nx, RPC); end
    tick();
    #1;
    n_assert++; if (val !== 1'b0) begin n_fail++; $display("FAIL stream_val_c1: got %b required 0", val); end
    tick();
    for (int k = 0; k < 6; k++) begin
      #1;
      n_assert++; if (val !== 1'b1 || o_pc_r !== RPC + 32'(4*k) || o_in !== RPC + 32'(4*k)) begin
        n_fail++;
        $display("FAIL stream_head%0d: got val=%b pc=%h in=%h required 1 %h %h",
                 k, val, o_pc_r, o_in, RPC + 32'(4*k), RPC + 32'(4*k));
      end
      $display("stream: head %0d pc=%h in=%h", k, o_pc_r, o_in);
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset(); rdy = 1'b0;
    repeat (8) tick();
    #1;
    n_assert++; if (fire_q.size() != 4) begin
      n_fail++; $display("FAIL bp_req_count: got %0d required 4", fire_q.size()); end
    for (int i = 0; i < 4 && i < fire_q.size(); i++) begin
      n_assert++; if (fire_q[i] !== RPC + 32'(4*i)) begin
        n_fail++; $display("FAIL bp_req_addr%0d: got %h required %h", i, fire_q[i], RPC + 32'(4*i)); end
    end
    n_assert++; if (hs_rd4ls_val !== 1'b0) begin n_fail++; $display("FAIL bp_stalled: got %b required 0", hs_rd4ls_val); end
    rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_assert++; if (val !== 1'b1 || o_pc_r !== RPC + 32'(4*i) || o_in !== RPC + 32'(4*i)) begin
        n_fail++;
        $display("FAIL bp_drain%0d: got val=%b pc=%h in=%h required 1 %h", i, val, o_pc_r, o_in, RPC + 32'(4*i));
      end
      $display("backpressure: drain %0d pc=%h", i, o_pc_r);
      tick();
    end
    n_assert++; if (fire_q.size() < 5) begin
      n_fail++; $display("FAIL bp_resume: got %0d requests required at least 5", fire_q.size());
    end else if (fire_q[4] !== 32'h80000010) begin
      n_fail++; $display("FAIL bp_resume: got %h required 80000010", fire_q[4]);
    end
  endtask

  task automatic test_redirect_outst();
    do_reset(); hold = 1'b1;
    tick(); tick();
    i_setpc = 1'b1; i_pc = 32'h100; i_pcadd = 32'h20;
    #1;
    n_assert++; if (hs_rd4ls_val !== 1'b0) begin n_fail++; $display("FAIL redir_req_blocked: got %b required 0", hs_rd4ls_val); end
    tick();
    i_setpc = 1'b0; hold = 1'b0; rdy = 1'b1;
    #1;
    n_assert++; if (val !== 1'b0 || o_pc_nx !== 32'h120) begin
      n_fail++; $display("FAIL redir_next: got val=%b pc_nx=%h required 0 00000120", val, o_pc_nx); end
    tick(); tick();
    #1;
    n_assert++; if (val !== 1'b0 || hs_rd4ls_val !== 1'b1 || o_pc_nx !== 32'h120) begin
      n_fail++; $display("FAIL redir_drop1: got val=%b req=%b pc_nx=%h required 0 1 00000120", val, hs_rd4ls_val, o_pc_nx); end
    tick();
    #1;
    n_assert++; if (val !== 1'b0) begin n_fail++; $display("FAIL redir_drop2: got val=%b required 0", val); end
    tick();
    #1;
    n_assert++; if (val !== 1'b1 || o_pc_r !== 32'h120 || o_in !== 32'h120) begin
      n_fail++; $display("FAIL redir_first: got val=%b pc=%h in=%h required 1 00000120 00000120", val, o_pc_r, o_in); end
    $display("redirect: first delivered pc=%h", o_pc_r);
  endtask

  task automatic test_redirect_same_cycle();
    do_reset(); rdy = 1'b1;
    tick(); tick();
    #1;
    n_assert++; if (val !== 1'b1 || i_rsp_val !== 1'b1) begin
      n_fail++; $display("FAIL same_setup: got val=%b rsp=%b required 1 1", val, i_rsp_val); end
    i_setpc = 1'b1; i_pc = 32'h200; i_pcadd = 32'h40;
    tick();
    i_setpc = 1'b0;
    #1;
    n_assert++; if (val !== 1'b0 || hs_rd4ls_val !== 1'b1 || o_pc_nx !== 32'h240) begin
      n_fail++; $display("FAIL same_next: got val=%b req=%b pc_nx=%h required 0 1 00000240", val, hs_rd4ls_val, o_pc_nx); end
    tick();
    #1;
    n_assert++; if (val !== 1'b0) begin n_fail++; $display("FAIL same_stale: got val=%b required 0", val); end
    tick();
    #1;
    n_assert++; if (val !== 1'b1 || o_pc_r !== 32'h240 || o_in !== 32'h240) begin
      n_fail++; $display("FAIL same_first: got val=%b pc=%h in=%h required 1 00000240 00000240", val, o_pc_r, o_in); end
    $display("same-cycle redirect: first delivered pc=%h", o_pc_r);
  endtask

  task automatic test_wrap();
    do_reset(); rdy = 1'b1;
    i_setpc = 1'b1; i_pc = 32'hFFFFFFF8; i_pcadd = 32'h4;
    tick();
    i_setpc = 1'b0;
    #1;
    n_assert++; if (o_pc_nx !== 32'hFFFFFFFC || hs_rd4ls_val !== 1'b1) begin
      n_fail++; $display("FAIL wrap_req0: got req=%b pc_nx=%h required 1 fffffffc", hs_rd4ls_val, o_pc_nx); end
    tick();
    #1;
    n_assert++; if (o_pc_nx !== 32'h0) begin n_fail++; $display("FAIL wrap_req1: got %h required 00000000", o_pc_nx); end
    tick(); #1;
    n_assert++; if (val !== 1'b1 || o_pc_r !== 32'hFFFFFFFC || o_in !== 32'hFFFFFFFC) begin
      n_fail++; $display("FAIL wrap_head0: got val=%b pc=%h in=%h required 1 fffffffc fffffffc", val, o_pc_r, o_in); end
    tick(); #1;
    n_assert++; if (val !== 1'b1 || o_pc_r !== 32'h0 || o_in !== 32'h0) begin
      n_fail++; $display("FAIL wrap_head1: got val=%b pc=%h in=%h required 1 00000000 00000000", val, o_pc_r, o_in); end
    $display("wrap: head pc=%h after fffffffc", o_pc_r);
  endtask

  task automatic test_async_reset();
    do_reset(); rdy = 1'b1;
    repeat (4) tick();
    #1;
    n_assert++; if (val !== 1'b1) begin n_fail++; $display("FAIL areset_pre: got val=%b required 1", val); end
    #2;
    rst_n = 1'b0; i_rsp_val = 1'b0; i_in_r = '0; mem_q.delete();
    #1;
    n_assert++; if (val !== 1'b0 || hs_rd4ls_val !== 1'b0 || o_in !== 32'h0 || o_pc_r !== RPC || o_pc_nx !== RPC) begin
      n_fail++;
      $display("FAIL areset_now: got val=%b req=%b in=%h pc=%h pc_nx=%h required 0 0 00000000 %h %h",
               val, hs_rd4ls_val, o_in, o_pc_r, o_pc_nx, RPC, RPC);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1; i_rsp_val = 1'b1; i_in_r = 32'hDEADBEEF; inject_late = 1'b1;
    #1;
    n_assert++; if (hs_rd4ls_val !== 1'b1 || o_pc_nx !== RPC) begin
      n_fail++; $display("FAIL areset_restart: got req=%b pc_nx=%h required 1 %h", hs_rd4ls_val, o_pc_nx, RPC); end
    tick();
    #1;
    n_assert++; if (val !== 1'b0) begin n_fail++; $display("FAIL areset_late_ignored: got val=%b required 0", val); end
    tick();
    #1;
    n_assert++; if (val !== 1'b1 || o_in !== RPC || o_pc_r !== RPC) begin
      n_fail++; $display("FAIL areset_first: got val=%b in=%h pc=%h required 1 %h %h", val, o_in, o_pc_r, RPC, RPC); end
    $display("async reset: first delivered pc=%h in=%h", o_pc_r, o_in);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_outst();
    test_redirect_same_cycle();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
